// File: rtl/ping_pong_rd_ctrl.sv
// ping_pong_rd_ctrl
// Read-side controller for the two-bank ping-pong input buffer. It waits for
// the current bank to be reported full, then steps port-A (even tile row) and
// port-B (odd tile row) read addresses into the systolic matmul. It moves on
// one output tile per accumulator completion, and hands each bank back to the
// writer once all its tiles are consumed. Banks are served in strict alternation.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bank_full_i[1:0]           level, bank b holds a complete fill
//   bank_release_o[1:0]        one-cycle pulse, reader done with bank b
//   systolic_finish_i          pulse, current k-step complete
//   acc_done_i                 level, rising edge = output tile done
//   bankN_ena_o/enb_o          read enables for bank N
//   bankN_addra_o/addrb_o      read addresses for bank N (0 when not selected)
//   rd_bank_o                  bank that drives the matmul data mux
//   enable_matmul              matmul core enable
//   reset_acc_o                one-cycle accumulator clear between tiles
//   tile_row_o, tile_col_o     current output tile
//   err_o                      sticky: selected bank lost its full flag mid-use
module ping_pong_rd_ctrl #(
  parameter  int ADDR_WIDTH   = 4,
  parameter  int INNER_BLOCKS = 2,
  parameter  int ROW_PAIRS    = 2,
  parameter  int COL_BLOCKS   = 2,
  localparam int KW = (INNER_BLOCKS > 1) ? $clog2(INNER_BLOCKS) : 1,
  localparam int RW = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1,
  localparam int CW = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            bank_full_i,
  output logic [1:0]            bank_release_o,
  input  logic                  systolic_finish_i,
  input  logic                  acc_done_i,
  output logic                  bank0_ena_o,
  output logic                  bank0_enb_o,
  output logic [ADDR_WIDTH-1:0] bank0_addra_o,
  output logic [ADDR_WIDTH-1:0] bank0_addrb_o,
  output logic                  bank1_ena_o,
  output logic                  bank1_enb_o,
  output logic [ADDR_WIDTH-1:0] bank1_addra_o,
  output logic [ADDR_WIDTH-1:0] bank1_addrb_o,
  output logic                  rd_bank_o,
  output logic                  enable_matmul,
  output logic                  reset_acc_o,
  output logic [RW-1:0]         tile_row_o,
  output logic [CW-1:0]         tile_col_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN      = 3'd2,
    TILE_END = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam logic [KW-1:0] K_LAST = KW'(INNER_BLOCKS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROW_PAIRS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COL_BLOCKS - 1);

  // Bank row (2*row + odd) holds INNER_BLOCKS consecutive k-blocks.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [KW-1:0] k,
                                                    input logic [RW-1:0] row,
                                                    input logic          odd);
    int a;
    a = int'(k) + INNER_BLOCKS * (2 * int'(row) + int'(odd));
    return a[ADDR_WIDTH-1:0];
  endfunction

  state_t    r_state;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_next_bank, r_rd_bank, r_en, r_mm, r_racc, r_err, r_acc_d;
  logic [1:0]    r_rel;

  state_t        w_state;
  logic [KW-1:0] w_k;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_next_bank, w_rd_bank, w_en, w_mm, w_racc, w_err, w_acc_rise;
  logic          w_sel0, w_sel1;
  logic [1:0]    w_rel;
  logic [ADDR_WIDTH-1:0] w_addra, w_addrb;

  assign w_acc_rise = acc_done_i & ~r_acc_d;

  always_comb begin
    w_state     = r_state;
    w_k         = r_k;
    w_row       = r_row;
    w_col       = r_col;
    w_next_bank = r_next_bank;
    w_rd_bank   = r_rd_bank;
    w_en        = r_en;
    w_mm        = r_mm;
    w_racc      = 1'b0;
    w_rel       = 2'b00;
    w_err       = r_err;
    if ((r_state == LOAD || r_state == RUN || r_state == TILE_END) &&
        !bank_full_i[r_rd_bank])
      w_err = 1'b1;
    case (r_state)
      IDLE: begin
        // Only the bank whose turn it is may start a read pass.
        w_rd_bank = r_next_bank;
        w_en      = 1'b0;
        if (bank_full_i[r_next_bank]) begin
          w_state = LOAD;
          w_en    = 1'b1;
          w_k     = '0;
        end
      end
      LOAD: begin
        w_state = RUN;
        w_mm    = 1'b1;
      end
      RUN: begin
        // Tile completion wins; a same-cycle k-step finish is dropped.
        if (w_acc_rise) begin
          w_state = TILE_END;
          w_racc  = 1'b1;
          w_mm    = 1'b0;
        end else if (systolic_finish_i && (r_k < K_LAST)) begin
          w_k = r_k + 1'b1;
        end
      end
      TILE_END: begin
        w_k = '0;
        if (r_row == R_LAST && r_col == C_LAST) begin
          w_row          = '0;
          w_col          = '0;
          w_state        = RELEASE;
          w_en           = 1'b0;
          w_rel[r_rd_bank] = 1'b1;
        end else begin
          w_state = LOAD;
          if (r_col < C_LAST) begin
            w_col = r_col + 1'b1;
          end else begin
            w_col = '0;
            w_row = r_row + 1'b1;
          end
        end
      end
      RELEASE: begin
        w_next_bank = ~r_next_bank;
        w_rd_bank   = ~r_next_bank;
        w_state     = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign w_sel0  = w_en & ~w_rd_bank;
  assign w_sel1  = w_en &  w_rd_bank;
  assign w_addra = addr_of(w_k, w_row, 1'b0);
  assign w_addrb = addr_of(w_k, w_row, 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_k           <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_next_bank   <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_en          <= 1'b0;
      r_mm          <= 1'b0;
      r_racc        <= 1'b0;
      r_rel         <= 2'b00;
      r_err         <= 1'b0;
      r_acc_d       <= 1'b0;
      bank0_ena_o   <= 1'b0;
      bank0_enb_o   <= 1'b0;
      bank0_addra_o <= '0;
      bank0_addrb_o <= '0;
      bank1_ena_o   <= 1'b0;
      bank1_enb_o   <= 1'b0;
      bank1_addra_o <= '0;
      bank1_addrb_o <= '0;
    end else begin
      r_state       <= w_state;
      r_k           <= w_k;
      r_row         <= w_row;
      r_col         <= w_col;
      r_next_bank   <= w_next_bank;
      r_rd_bank     <= w_rd_bank;
      r_en          <= w_en;
      r_mm          <= w_mm;
      r_racc        <= w_racc;
      r_rel         <= w_rel;
      r_err         <= w_err;
      r_acc_d       <= acc_done_i;
      bank0_ena_o   <= w_sel0;
      bank0_enb_o   <= w_sel0;
      bank0_addra_o <= w_sel0 ? w_addra : '0;
      bank0_addrb_o <= w_sel0 ? w_addrb : '0;
      bank1_ena_o   <= w_sel1;
      bank1_enb_o   <= w_sel1;
      bank1_addra_o <= w_sel1 ? w_addra : '0;
      bank1_addrb_o <= w_sel1 ? w_addrb : '0;
    end
  end

  assign bank_release_o = r_rel;
  assign rd_bank_o      = r_rd_bank;
  assign enable_matmul  = r_mm;
  assign reset_acc_o    = r_racc;
  assign tile_row_o     = r_row;
  assign tile_col_o     = r_col;
  assign err_o          = r_err;

endmodule

// File: tb/tb_ping_pong_rd_ctrl.sv
// Directed bench for ping_pong_rd_ctrl with default parameters.
module tb_ping_pong_rd_ctrl;
  logic       clk, rst_n;
  logic [1:0] bank_full_i, bank_release_o;
  logic       systolic_finish_i, acc_done_i;
  logic       bank0_ena_o, bank0_enb_o, bank1_ena_o, bank1_enb_o;
  logic [3:0] bank0_addra_o, bank0_addrb_o, bank1_addra_o, bank1_addrb_o;
  logic       rd_bank_o, enable_matmul, reset_acc_o, err_o;
  logic [0:0] tile_row_o, tile_col_o;

  int n_cmp = 0;
  int n_err = 0;

  ping_pong_rd_ctrl #(.ADDR_WIDTH(4), .INNER_BLOCKS(2), .ROW_PAIRS(2), .COL_BLOCKS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .bank_full_i(bank_full_i), .bank_release_o(bank_release_o),
    .systolic_finish_i(systolic_finish_i), .acc_done_i(acc_done_i),
    .bank0_ena_o(bank0_ena_o), .bank0_enb_o(bank0_enb_o),
    .bank0_addra_o(bank0_addra_o), .bank0_addrb_o(bank0_addrb_o),
    .bank1_ena_o(bank1_ena_o), .bank1_enb_o(bank1_enb_o),
    .bank1_addra_o(bank1_addra_o), .bank1_addrb_o(bank1_addrb_o),
    .rd_bank_o(rd_bank_o), .enable_matmul(enable_matmul), .reset_acc_o(reset_acc_o),
    .tile_row_o(tile_row_o), .tile_col_o(tile_col_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From LOAD: run one tile to completion with a single acc_done edge.
  task automatic do_tile();
    tick();
    acc_done_i = 1'b1;
    tick();
    acc_done_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bank_full_i = 2'b00;
    systolic_finish_i = 1'b0;
    acc_done_i = 1'b0;
    tick();
    tick();
    chk("rst_b0_ena", bank0_ena_o, 1'b0);
    chk("rst_b1_ena", bank1_ena_o, 1'b0);
    chk("rst_mm", enable_matmul, 1'b0);
    chk("rst_rel", bank_release_o, 2'b00);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdbank", rd_bank_o, 1'b0);
    rst_n = 1'b1;

    // Bank 1 full first must be ignored while bank 0 is due.
    bank_full_i = 2'b10;
    tick();
    tick();
    chk("ign_b0_ena", bank0_ena_o, 1'b0);
    chk("ign_b1_ena", bank1_ena_o, 1'b0);
    chk("ign_rdbank", rd_bank_o, 1'b0);

    bank_full_i = 2'b01;
    tick();
    chk("load_b0_ena", bank0_ena_o, 1'b1);
    chk("load_b0_enb", bank0_enb_o, 1'b1);
    chk("load_b0_addra", bank0_addra_o, 4'd0);
    chk("load_b0_addrb", bank0_addrb_o, 4'd2);
    chk("load_b1_ena", bank1_ena_o, 1'b0);
    chk("load_mm", enable_matmul, 1'b0);
    tick();
    chk("run_mm", enable_matmul, 1'b1);

    // Tile 00: two k-step pulses, second must saturate at k=1.
    systolic_finish_i = 1'b1; tick(); systolic_finish_i = 1'b0;
    chk("t00_k1_addra", bank0_addra_o, 4'd1);
    chk("t00_k1_addrb", bank0_addrb_o, 4'd3);
    systolic_finish_i = 1'b1; tick(); systolic_finish_i = 1'b0;
    chk("t00_hold_addra", bank0_addra_o, 4'd1);
    chk("t00_hold_addrb", bank0_addrb_o, 4'd3);
    acc_done_i = 1'b1; tick();
    chk("t00_te_racc", reset_acc_o, 1'b1);
    chk("t00_te_mm", enable_matmul, 1'b0);
    acc_done_i = 1'b0; tick();
    chk("t01_racc", reset_acc_o, 1'b0);
    chk("t01_row", tile_row_o, 1'b0);
    chk("t01_col", tile_col_o, 1'b1);
    chk("t01_addra", bank0_addra_o, 4'd0);
    tick();

    // Tile 01: finish and acc edge in the same cycle, finish dropped.
    systolic_finish_i = 1'b1; acc_done_i = 1'b1; tick();
    systolic_finish_i = 1'b0;
    chk("same_te_racc", reset_acc_o, 1'b1);
    chk("same_addra", bank0_addra_o, 4'd0);
    chk("same_addrb", bank0_addrb_o, 4'd2);
    acc_done_i = 1'b0; tick();
    chk("t10_row", tile_row_o, 1'b1);
    chk("t10_col", tile_col_o, 1'b0);
    chk("t10_addra", bank0_addra_o, 4'd4);
    chk("t10_addrb", bank0_addrb_o, 4'd6);
    tick();

    // Tile 10: row 1 k-step addresses.
    systolic_finish_i = 1'b1; tick(); systolic_finish_i = 1'b0;
    chk("t10_k1_addra", bank0_addra_o, 4'd5);
    chk("t10_k1_addrb", bank0_addrb_o, 4'd7);
    systolic_finish_i = 1'b1; tick(); systolic_finish_i = 1'b0;
    chk("t10_hold_addra", bank0_addra_o, 4'd5);
    chk("t10_hold_addrb", bank0_addrb_o, 4'd7);
    acc_done_i = 1'b1; tick(); acc_done_i = 1'b0; tick();
    chk("t11_row", tile_row_o, 1'b1);
    chk("t11_col", tile_col_o, 1'b1);
    chk("t11_addra", bank0_addra_o, 4'd4);
    tick();
    acc_done_i = 1'b1; tick();
    chk("t11_te_racc", reset_acc_o, 1'b1);
    chk("t11_te_rel", bank_release_o, 2'b00);
    acc_done_i = 1'b0; tick();
    chk("rel0_pulse", bank_release_o, 2'b01);
    chk("rel0_b0_ena", bank0_ena_o, 1'b0);
    chk("rel0_row", tile_row_o, 1'b0);
    tick();
    chk("rel0_end", bank_release_o, 2'b00);
    chk("idle_rdbank1", rd_bank_o, 1'b1);
    tick();
    chk("idle_wait_b1_ena", bank1_ena_o, 1'b0);
    chk("idle_wait_b0_ena", bank0_ena_o, 1'b0);

    // Both full: bank 1 now, then bank 0 again.
    bank_full_i = 2'b11;
    tick();
    chk("load_b1_ena", bank1_ena_o, 1'b1);
    chk("load_b1_addrb", bank1_addrb_o, 4'd2);
    chk("load_b1_b0_ena", bank0_ena_o, 1'b0);
    chk("load_b1_b0_addra", bank0_addra_o, 4'd0);
    chk("load_b1_rdbank", rd_bank_o, 1'b1);
    do_tile(); do_tile(); do_tile(); do_tile();
    chk("rel1_pulse", bank_release_o, 2'b10);
    tick();
    chk("rel1_end", bank_release_o, 2'b00);
    chk("alt_rdbank0", rd_bank_o, 1'b0);
    tick();
    chk("alt_b0_ena", bank0_ena_o, 1'b1);
    chk("alt_b1_ena", bank1_ena_o, 1'b0);
    tick();
    chk("pre_err", err_o, 1'b0);

    // Drop bank 0 full mid-run: sticky error.
    bank_full_i = 2'b10; tick();
    chk("err_set", err_o, 1'b1);
    bank_full_i = 2'b11; tick();
    chk("err_sticky", err_o, 1'b1);
    chk("err_mm_cont", enable_matmul, 1'b1);

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mm", enable_matmul, 1'b0);
    chk("arst_err", err_o, 1'b0);
    chk("arst_b0_ena", bank0_ena_o, 1'b0);
    chk("arst_rel", bank_release_o, 2'b00);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_rel", bank_release_o, 2'b00);
    chk("post_rst_rdbank", rd_bank_o, 1'b0);
    chk("post_rst_b0_ena", bank0_ena_o, 1'b1);
    chk("post_rst_b1_ena", bank1_ena_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ping_pong_rd_ctrl.md
Name: ping_pong_rd_ctrl

Overview:
- Read-side (consumer) controller for the two-bank ping-pong input buffer; the counterpart of the write/fill controller.
- Waits for a bank to be reported full, then sequences port-A (even tile row) and port-B (odd tile row) read addresses into the systolic matmul, one inner-dimension block per systolic_finish.
- Advances the output tile (row pair, column) on each accumulator completion.
- When every tile of a bank has been consumed, releases that bank back to the writer and moves to the other bank in strict alternation.

Parameters:
- ADDR_WIDTH, 4, bank address width; must satisfy 2^ADDR_WIDTH >= 2*ROW_PAIRS*INNER_BLOCKS.
- INNER_BLOCKS, 2, INNER_DIMENSION/BLOCK_SIZE; k-steps per output tile.
- ROW_PAIRS, 2, tile-row pairs held per bank.
- COL_BLOCKS, 2, output tile columns (COL_SIZE_MAT_C).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- bank_full_i  in  2  level; bit b=1 means bank b holds a complete fill.
- bank_release_o  out  2  one-cycle pulse on bit b when the reader has finished with bank b.
- systolic_finish_i  in  1  one-cycle pulse; the current k-step is complete.
- acc_done_i  in  1  level; its rising edge marks one output tile done.
- bank0_ena_o, bank0_enb_o  out  1 each  read enables, bank 0.
- bank0_addra_o, bank0_addrb_o  out  ADDR_WIDTH each  read addresses, bank 0.
- bank1_ena_o, bank1_enb_o, bank1_addra_o, bank1_addrb_o  out  as for bank 0, bank 1.
- rd_bank_o  out  1  selects the bank driving the matmul data mux.
- enable_matmul  out  1  matmul core enable.
- reset_acc_o  out  1  one-cycle accumulator clear between tiles.
- tile_row_o  out  clog2(ROW_PAIRS)  current row pair.
- tile_col_o  out  clog2(COL_BLOCKS)  current column.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset is asynchronous. All outputs, counters k/row/col, and the acc_done edge register go to 0, state goes to IDLE, next_bank=0. Reset mid-operation aborts without issuing any release pulse.
- All outputs are registered.
- Addresses: addra = k + INNER_BLOCKS*(2*row); addrb = k + INNER_BLOCKS*(2*row+1).
- Only the bank equal to rd_bank_o gets ena/enb=1 and live addresses. The other bank's en=0 and addr=0.
- acc_rise = acc_done_i & ~acc_done_d.
- FSM states:
  - IDLE: rd_bank_o=next_bank. If bank_full_i[next_bank]=1, go to LOAD. The other bank's full flag is ignored, even if it is set first.
  - LOAD: one cycle covering BRAM read latency. ena/enb=1, addresses for (row, col, k=0). Go to RUN; enable_matmul rises on entering RUN.
  - RUN:
    - On systolic_finish_i with k<INNER_BLOCKS-1: k<=k+1; the new addresses appear the next cycle.
    - On systolic_finish_i with k=INNER_BLOCKS-1: hold k and the addresses.
    - On acc_rise: go to TILE_END. acc_rise has priority over a same-cycle systolic_finish_i, which is dropped.
  - TILE_END:
    - reset_acc_o=1 for this cycle only; k<=0; enable_matmul=0.
    - If col<COL_BLOCKS-1: col++.
    - Otherwise: col<=0; row++.
    - If (row, col) was the last tile (ROW_PAIRS-1, COL_BLOCKS-1): go to RELEASE with row<=0. Otherwise go to LOAD.
  - RELEASE: bank_release_o[rd_bank]=1 for one cycle; next_bank<=~next_bank; go to IDLE.
- Latency: bank_full_i[b] sampled high in IDLE at cycle t gives enables and addresses at t+1 (LOAD) and enable_matmul=1 at t+2.
- Error: if bank_full_i[rd_bank_o] falls while in LOAD, RUN or TILE_END, err_o<=1 (sticky until reset). Sequencing continues unchanged.
- systolic_finish_i and acc_rise arriving in IDLE or RELEASE are ignored. acc_done_d is still updated every cycle.

Test Plan:
- Defaults; assert bank_full_i=01 at cycle 5 -> LOAD at cycle 6 with bank0 addra=0, addrb=2; enable_matmul=1 at cycle 7; bank1 en=0.
- In RUN with row=1, pulse systolic_finish_i once -> k=1, addra=5, addrb=7 on the next cycle. A second pulse leaves the addresses unchanged.
- Four acc_done rising edges -> tile (row,col) sequence 00, 01, 10, 11. reset_acc_o pulses 4 times. bank_release_o=01 for exactly one cycle after the 4th edge, then rd_bank_o=1.
- bank_full_i=11 from reset -> bank 0 served first, then bank 1, then bank 0 again; never bank 1 twice in a row.
- systolic_finish_i and acc_done_i rise in the same cycle -> TILE_END taken; k=0 at the next LOAD; no k increment.
- Drop bank_full_i[0] mid-RUN -> err_o=1 and stays 1. Assert rst_n=0 mid-RUN -> all outputs 0 immediately (asynchronous), no release pulse, next_bank=0.
